// File: rtl/wb_daq_dma_scheduler.sv
// Round-robin N-channel DAQ scheduler writing each channel into its own circular buffer via Wishbone classic single writes.
// Optional `WB_DAQ_DMA_RETRY_EN: reissue on rty up to RETRY_MAX times before flagging an error (default build treats rty as err).
module wb_daq_dma_scheduler #(
  parameter int NUM_CH    = 4,
  parameter int DW        = 32,
  parameter int AW        = 32,
  parameter int LEN_W     = 16,
  parameter int RETRY_MAX = 3
) (
  input  logic                    wb_clk,
  input  logic                    wb_rst_n,
  input  logic [NUM_CH-1:0]       ch_enable_i,
  input  logic [NUM_CH-1:0]       ch_valid_i,
  input  logic [NUM_CH*DW-1:0]    ch_data_i,
  output logic [NUM_CH-1:0]       ch_ready_o,
  input  logic [NUM_CH*AW-1:0]    ch_base_i,
  input  logic [NUM_CH*LEN_W-1:0] ch_len_i,
  output logic [AW-1:0]           wb_adr_o,
  output logic [DW-1:0]           wb_dat_o,
  output logic [DW/8-1:0]         wb_sel_o,
  output logic                    wb_we_o,
  output logic                    wb_cyc_o,
  output logic                    wb_stb_o,
  output logic [2:0]              wb_cti_o,
  output logic [1:0]              wb_bte_o,
  input  logic                    wb_ack_i,
  input  logic                    wb_err_i,
  input  logic                    wb_rty_i,
  output logic [NUM_CH-1:0]       grant_o,
  output logic [NUM_CH-1:0]       wrap_o,
  output logic [NUM_CH-1:0]       err_o,
  input  logic [NUM_CH-1:0]       err_clr_i,
  output logic                    busy_o
);

  localparam int CW  = $clog2(NUM_CH);
  localparam int BPW = DW / 8;

  if (NUM_CH < 2 || NUM_CH > 16 || (DW % 8) != 0 || RETRY_MAX < 1) begin : g_bad_param
    $error("wb_daq_dma_scheduler: unsupported parameter set");
  end

  // state   | meaning
  // S_IDLE  | arbitrate; accept one word from the winning channel
  // S_BUS   | Wishbone write outstanding, waiting for ack/err/rty
  // S_RWAIT | one cyc-low cycle before reissuing a retried write
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BUS   = 2'd1;
`ifdef WB_DAQ_DMA_RETRY_EN
  localparam logic [1:0] S_RWAIT = 2'd2;
  localparam int RW = $clog2(RETRY_MAX + 1);
  logic [RW-1:0] r_rty_cnt;
`endif

  logic [1:0]        r_state;
  logic [CW-1:0]     r_last;
  logic [CW-1:0]     r_cur;
  logic [NUM_CH-1:0] r_grant;
  logic [NUM_CH-1:0] r_wrap;
  logic [NUM_CH-1:0] r_err;
  logic [DW-1:0]     r_data;
  logic [AW-1:0]     r_adr;
  logic [LEN_W-1:0]  r_xoff;
  logic [LEN_W-1:0]  r_offset [NUM_CH];

  logic [NUM_CH-1:0] w_elig;
  logic [AW-1:0]     w_base [NUM_CH];
  logic [DW-1:0]     w_data [NUM_CH];
  logic [LEN_W-1:0]  w_len  [NUM_CH];
  logic              w_found;
  logic [CW-1:0]     w_pick;
  int                w_idx;
  logic              w_start;
  logic              w_in_bus;
  logic [LEN_W:0]    w_off_inc;
  logic              w_wrap_hit;
  logic [LEN_W-1:0]  w_next_off;
  logic              w_rty_fatal;
  logic [NUM_CH-1:0] w_err_set;

  function automatic logic [NUM_CH-1:0] f_onehot(input logic [CW-1:0] idx);
    f_onehot      = '0;
    f_onehot[idx] = 1'b1;
  endfunction

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      w_base[c] = ch_base_i[c*AW +: AW];
      w_data[c] = ch_data_i[c*DW +: DW];
      w_len[c]  = ch_len_i[c*LEN_W +: LEN_W];
      w_elig[c] = ch_enable_i[c] & ch_valid_i[c] & (w_len[c] != '0);
    end
  end

  // first eligible channel after the previous winner, modulo NUM_CH
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_idx = int'(r_last) + 1 + i;
      if (w_idx >= NUM_CH) w_idx = w_idx - NUM_CH;
      if (!w_found && w_elig[w_idx[CW-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_idx[CW-1:0];
      end
    end
  end

  assign w_start  = wb_rst_n && (r_state == S_IDLE) && w_found;
  assign w_in_bus = (r_state == S_BUS);

  // a shrunken length leaves offset >= len, which also wraps here
  assign w_off_inc  = {1'b0, r_xoff} + {{LEN_W{1'b0}}, 1'b1};
  assign w_wrap_hit = (w_off_inc >= {1'b0, w_len[r_cur]});
  assign w_next_off = w_wrap_hit ? '0 : w_off_inc[LEN_W-1:0];

`ifdef WB_DAQ_DMA_RETRY_EN
  assign w_rty_fatal = (r_rty_cnt == RW'(RETRY_MAX));
`else
  assign w_rty_fatal = 1'b1;
`endif

  always_comb begin
    w_err_set = '0;
    if (w_in_bus && !wb_ack_i && (wb_err_i || (wb_rty_i && w_rty_fatal)))
      w_err_set = f_onehot(r_cur);
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_state <= S_IDLE;
      r_last  <= CW'(NUM_CH - 1);
      r_cur   <= '0;
      r_grant <= '0;
      r_wrap  <= '0;
      r_err   <= '0;
      r_data  <= '0;
      r_adr   <= '0;
      r_xoff  <= '0;
      for (int c = 0; c < NUM_CH; c++) r_offset[c] <= '0;
`ifdef WB_DAQ_DMA_RETRY_EN
      r_rty_cnt <= '0;
`endif
    end else begin
      r_wrap <= '0;
      r_err  <= (r_err & ~err_clr_i) | w_err_set;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_cur   <= w_pick;
            r_last  <= w_pick;
            r_grant <= f_onehot(w_pick);
            r_data  <= w_data[w_pick];
            r_adr   <= w_base[w_pick] + AW'(r_offset[w_pick]) * AW'(BPW);
            r_xoff  <= r_offset[w_pick];
            r_state <= S_BUS;
`ifdef WB_DAQ_DMA_RETRY_EN
            r_rty_cnt <= '0;
`endif
          end
        end
        S_BUS: begin
          if (wb_ack_i) begin
            r_offset[r_cur] <= w_next_off;
            r_wrap          <= w_wrap_hit ? f_onehot(r_cur) : '0;
            r_grant         <= '0;
            r_state         <= S_IDLE;
          end else if (wb_err_i) begin
            r_grant <= '0;
            r_state <= S_IDLE;
          end else if (wb_rty_i) begin
`ifdef WB_DAQ_DMA_RETRY_EN
            if (w_rty_fatal) begin
              r_grant <= '0;
              r_state <= S_IDLE;
            end else begin
              r_rty_cnt <= r_rty_cnt + RW'(1);
              r_state   <= S_RWAIT;
            end
`else
            r_grant <= '0;
            r_state <= S_IDLE;
`endif
          end
        end
`ifdef WB_DAQ_DMA_RETRY_EN
        S_RWAIT: r_state <= S_BUS;
`endif
        default: r_state <= S_IDLE;
      endcase
      // disabled channels restart at their base; an in-flight write still completes
      for (int c = 0; c < NUM_CH; c++) begin
        if (!ch_enable_i[c]) r_offset[c] <= '0;
      end
    end
  end

  assign ch_ready_o = w_start ? f_onehot(w_pick) : '0;
  assign wb_cyc_o   = w_in_bus;
  assign wb_stb_o   = w_in_bus;
  assign wb_we_o    = w_in_bus;
  assign wb_adr_o   = w_in_bus ? r_adr : '0;
  assign wb_dat_o   = w_in_bus ? r_data : '0;
  assign wb_sel_o   = {BPW{w_in_bus}};
  assign wb_cti_o   = 3'b000;
  assign wb_bte_o   = 2'b00;
  assign grant_o    = r_grant;
  assign wrap_o     = r_wrap;
  assign err_o      = r_err;
  assign busy_o     = (r_state != S_IDLE);

endmodule

// File: doc/wb_daq_dma_scheduler.md
Name: wb_daq_dma_scheduler

Overview:
- Parametrised N-channel DAQ write scheduler.
- Accepts one data word at a time from each acquisition channel and arbitrates between channels round-robin.
- Issues Wishbone classic single writes into a per-channel circular buffer in memory.
- Successor to the fixed 4-channel request/arbiter/bus-master arrangement: scales channel count, widths and buffer depth, and adds address auto-increment, wrap detection and error capture.

Parameters:
- NUM_CH, 4, number of acquisition channels (2..16).
- DW, 32, data width of channel words and the Wishbone bus (multiple of 8).
- AW, 32, Wishbone address width.
- LEN_W, 16, width of the per-channel buffer length in words.
- RETRY_MAX, 3, maximum reissues after a retry (used only with the optional feature).

Ports:
- wb_clk  in  1  system clock
- wb_rst_n  in  1  asynchronous, active-low reset
- ch_enable_i  in  NUM_CH  per-channel enable
- ch_valid_i  in  NUM_CH  channel has a word to write
- ch_data_i  in  NUM_CH*DW  channel words; channel c occupies [c*DW +: DW]
- ch_ready_o  out  NUM_CH  one-cycle accept pulse back to the channel
- ch_base_i  in  NUM_CH*AW  buffer base byte address per channel
- ch_len_i  in  NUM_CH*LEN_W  buffer length in words per channel
- wb_adr_o  out  AW  write address
- wb_dat_o  out  DW  write data
- wb_sel_o  out  DW/8  byte selects, all ones
- wb_we_o  out  1  write enable
- wb_cyc_o  out  1  bus cycle
- wb_stb_o  out  1  strobe
- wb_cti_o  out  3  cycle type, always 3'b000
- wb_bte_o  out  2  burst type, always 2'b00
- wb_ack_i  in  1  acknowledge
- wb_err_i  in  1  bus error
- wb_rty_i  in  1  retry
- grant_o  out  NUM_CH  one-hot channel owning the current transfer
- wrap_o  out  NUM_CH  one-cycle pulse when a channel buffer wraps
- err_o  out  NUM_CH  sticky per-channel error flag
- err_clr_i  in  NUM_CH  clears err_o, one bit per channel
- busy_o  out  1  a transfer is in progress

Behaviour:
- Reset (wb_rst_n low, asynchronous): all outputs 0; state = IDLE; all offsets 0; round-robin pointer last = NUM_CH-1, so channel 0 has first priority.
- Eligible channel: ch_enable_i[c] & ch_valid_i[c] & (ch_len_i[c] != 0). A zero-length channel is never granted.
- IDLE, when at least one channel is eligible:
  - Pick the first eligible channel scanning from last+1 with modulo wrap.
  - Latch ch_data_i[c] into the data register.
  - Pulse ch_ready_o[c] for exactly one cycle; the valid/ready handshake completes in that cycle.
  - Set grant_o, set last = c, go to BUS.
  - Accept-to-stb latency is 1 cycle.
- BUS:
  - Drive wb_cyc_o = wb_stb_o = wb_we_o = 1 and busy_o = 1.
  - wb_adr_o = base[c] + offset[c]*(DW/8), truncated to AW bits.
  - wb_dat_o = latched word.
  - Hold all signals until ack, err or rty is sampled high.
- On wb_ack_i:
  - Drop cyc/stb the next cycle; clear grant_o; return to IDLE.
  - If offset[c] == ch_len_i[c]-1: set offset[c] to 0 and pulse wrap_o[c]. Otherwise increment offset[c].
- On wb_err_i: set err_o[c]; discard the word; leave offset[c] unchanged; return to IDLE.
- On wb_rty_i without the optional feature: handled identically to wb_err_i.
- If ack, err and rty are sampled high together, priority is ack > err > rty.
- Back-to-back transfers: IDLE lasts at least 1 cycle between transfers; cyc is deasserted for at least 1 cycle.
- Offset register width is LEN_W. If ch_len_i[c] changes so that offset[c] >= new length, the next ack wraps offset[c] to 0.
- Whenever ch_enable_i[c] is low, offset[c] is held at 0. Re-enabling a channel restarts it at its base address.
- Deasserting ch_enable_i[c] during BUS does not abort the transfer. The transfer completes, and on ack offset[c] is then forced to 0.
- err_clr_i[c] clears err_o[c]. If a set and a clear happen in the same cycle, the set wins.
- Reset asserted mid-transfer: cyc/stb drop immediately (asynchronously); the in-flight word is lost.

Optional Feature:
- Macro: WB_DAQ_DMA_RETRY_EN.
- Defined:
  - wb_rty_i causes a return to BUS after 1 idle cycle with cyc low, reissuing the same address and data without re-arbitrating.
  - A per-transfer retry counter (width clog2(RETRY_MAX+1)) increments on each retry.
  - A retry received when the counter already equals RETRY_MAX sets err_o[c] and drops the word.
  - The counter clears on every new grant.
- Undefined: rty is treated as err; no retry counter is instantiated.

Test Plan:
- Single channel 0: base 32'h1000_0000, len 4, 6 words, ack after 2 cycles -> addresses 0x1000_0000, 0x04, 0x08, 0x0C, then 0x1000_0000, 0x04; exactly one wrap_o[0] pulse, on the 4th ack.
- All 4 channels with valid held high, zero-wait ack -> grant order 0,1,2,3,0,1; each ch_ready_o pulse lasts 1 cycle; cyc low for at least 1 cycle between transfers.
- Channel 2 with len 0 and valid high, channel 1 valid -> only channel 1 is granted; channel 2 never gets ch_ready_o.
- wb_err_i on channel 1 write to 0x2000_0008 -> err_o[1] = 1; next channel 1 write reuses 0x2000_0008; err_clr_i[1] pulse -> err_o[1] = 0.
- ch_enable_i[0] dropped during BUS at offset 3 -> transfer completes at base+12; after re-enable the next address is base+0.
- With WB_DAQ_DMA_RETRY_EN and RETRY_MAX 3, rty answered 4 times -> 4 strobes with identical address and data, then err_o set. Without the macro -> first rty sets err_o and there is no reissue.
